// File: rtl/baud_frac_gen.sv
// Fractional baud/acquisition timing generator: acq, mid-bit, bit and frame strobes
// with per-bit (normal/compensated acq periods) and per-frame (long/short bit) compensation.
module baud_frac_gen #(
    parameter int PERIOD_W = 13,
    parameter int OSR_W    = 4,
    parameter int FRAME_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   BaudEn_i,
    input  logic                   Restart_i,
    input  logic [PERIOD_W-1:0]    AcqPeriod_i,
    input  logic [2*OSR_W-1:0]     PosComp_i,
    input  logic [2*OSR_W-1:0]     NegComp_i,
    input  logic [2*FRAME_W-1:0]   FrameComp_i,
    output logic                   AcqSig_o,
    output logic                   MidSig_o,
    output logic                   BaudSig_o,
    output logic                   FrameSig_o,
    output logic                   BitType_o,
    output logic [FRAME_W:0]       BitIndex_o
);
    localparam int NW = OSR_W + 1;

    function automatic logic [NW-1:0] ceil_half(input logic [NW-1:0] n);
        return n - (n >> 1);
    endfunction

    logic                 r_run;
    logic [PERIOD_W-1:0]  r_p;
    logic [2*OSR_W-1:0]   r_pos_comp;
    logic [2*OSR_W-1:0]   r_neg_comp;
    logic [PERIOD_W:0]    r_acq_cnt;
    logic [NW-1:0]        r_acq_idx;
    logic [FRAME_W-1:0]   r_pos_left;
    logic [FRAME_W-1:0]   r_neg_left;
    logic                 r_bit_type;
    logic [FRAME_W:0]     r_bit_idx;
    logic                 r_acq, r_mid, r_baud, r_frame;

    logic [2*OSR_W-1:0]   w_bit_cfg;
    logic [NW-1:0]        w_norm;
    logic [NW-1:0]        w_n;
    logic                 w_in_comp;
    logic                 w_acq_last;
    logic                 w_bit_last;
    logic                 w_mid_hit;
    logic                 w_frame_last;
    logic                 w_start;
    logic                 w_load;
    logic [FRAME_W-1:0]   w_pl;
    logic [FRAME_W-1:0]   w_nl;
    logic                 w_next_pos;
    logic [FRAME_W-1:0]   w_pl_dec;
    logic [FRAME_W-1:0]   w_nl_dec;

    // Current bit geometry; an empty bit degenerates to one normal period.
    always_comb begin
        w_bit_cfg = r_bit_type ? r_pos_comp : r_neg_comp;
        w_norm    = {1'b0, w_bit_cfg[2*OSR_W-1:OSR_W]};
        w_n       = w_norm + {1'b0, w_bit_cfg[OSR_W-1:0]};
        if (w_n == '0) begin
            w_norm = NW'(1);
            w_n    = NW'(1);
        end
        w_in_comp    = (r_acq_idx >= w_norm);
        w_acq_last   = (r_acq_cnt == ({1'b0, r_p} + {{PERIOD_W{1'b0}}, w_in_comp}));
        w_bit_last   = w_acq_last && (r_acq_idx == w_n - NW'(1));
        w_mid_hit    = w_acq_last && (r_acq_idx == ceil_half(w_n) - NW'(1));
        w_frame_last = w_bit_last && (r_pos_left == '0) && (r_neg_left == '0);
    end

    assign w_start = BaudEn_i && (!r_run || Restart_i);
    assign w_load  = w_start || w_frame_last;

    // Next bit type: long bit only while strictly more long bits remain.
    always_comb begin
        w_pl       = w_load ? FrameComp_i[2*FRAME_W-1:FRAME_W] : r_pos_left;
        w_nl       = w_load ? FrameComp_i[FRAME_W-1:0]         : r_neg_left;
        w_next_pos = (w_pl > w_nl);
        w_pl_dec   = w_next_pos ? (w_pl - FRAME_W'(1)) : w_pl;
        w_nl_dec   = (!w_next_pos && (w_nl != '0)) ? (w_nl - FRAME_W'(1)) : w_nl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_p        <= '0;
            r_pos_comp <= '0;
            r_neg_comp <= '0;
            r_acq_cnt  <= '0;
            r_acq_idx  <= '0;
            r_pos_left <= '0;
            r_neg_left <= '0;
            r_bit_type <= 1'b0;
            r_bit_idx  <= '0;
            r_acq      <= 1'b0;
            r_mid      <= 1'b0;
            r_baud     <= 1'b0;
            r_frame    <= 1'b0;
        end else if (!BaudEn_i) begin
            r_run      <= 1'b0;
            r_acq_cnt  <= '0;
            r_acq_idx  <= '0;
            r_pos_left <= '0;
            r_neg_left <= '0;
            r_bit_type <= 1'b0;
            r_bit_idx  <= '0;
            r_acq      <= 1'b0;
            r_mid      <= 1'b0;
            r_baud     <= 1'b0;
            r_frame    <= 1'b0;
        end else if (w_start) begin
            r_run      <= 1'b1;
            r_p        <= AcqPeriod_i;
            r_pos_comp <= PosComp_i;
            r_neg_comp <= NegComp_i;
            r_acq_cnt  <= '0;
            r_acq_idx  <= '0;
            r_pos_left <= w_pl_dec;
            r_neg_left <= w_nl_dec;
            r_bit_type <= w_next_pos;
            r_bit_idx  <= '0;
            r_acq      <= 1'b0;
            r_mid      <= 1'b0;
            r_baud     <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_acq   <= w_acq_last;
            r_mid   <= w_mid_hit;
            r_baud  <= w_bit_last;
            r_frame <= w_frame_last;
            if (w_acq_last) begin
                r_acq_cnt <= '0;
                if (w_bit_last) begin
                    r_acq_idx  <= '0;
                    r_pos_left <= w_pl_dec;
                    r_neg_left <= w_nl_dec;
                    r_bit_type <= w_next_pos;
                    r_bit_idx  <= w_frame_last ? '0 : (r_bit_idx + (FRAME_W+1)'(1));
                    // Configuration only takes effect on frame boundaries.
                    if (w_frame_last) begin
                        r_p        <= AcqPeriod_i;
                        r_pos_comp <= PosComp_i;
                        r_neg_comp <= NegComp_i;
                    end
                end else begin
                    r_acq_idx <= r_acq_idx + NW'(1);
                end
            end else begin
                r_acq_cnt <= r_acq_cnt + (PERIOD_W+1)'(1);
            end
        end
    end

    assign AcqSig_o   = r_acq;
    assign MidSig_o   = r_mid;
    assign BaudSig_o  = r_baud;
    assign FrameSig_o = r_frame;
    assign BitType_o  = r_bit_type;
    assign BitIndex_o = r_bit_idx;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Bench for baud_frac_gen: a cycle-schedule reference model built per frame from the
// configuration, plus directed latency/period checks taken straight from the timing rules.
module tb_baud_frac_gen;
    localparam int PW = 13;
    localparam int OW = 4;
    localparam int FW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            restart = 1'b0;
    logic [PW-1:0]   per = '0;
    logic [2*OW-1:0] posc = '0;
    logic [2*OW-1:0] negc = '0;
    logic [2*FW-1:0] fc = '0;
    logic            acq, mid, baud, frm, btype;
    logic [FW:0]     bidx;

    baud_frac_gen #(.PERIOD_W(PW), .OSR_W(OW), .FRAME_W(FW)) dut (
        .clk(clk), .rst(rst), .BaudEn_i(en), .Restart_i(restart),
        .AcqPeriod_i(per), .PosComp_i(posc), .NegComp_i(negc), .FrameComp_i(fc),
        .AcqSig_o(acq), .MidSig_o(mid), .BaudSig_o(baud), .FrameSig_o(frm),
        .BitType_o(btype), .BitIndex_o(bidx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        acq, mid, baud, frm, typ;
        logic [FW:0] idx;
    } ent_t;

    ent_t q[$];
    bit   run = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic ex_acq, ex_mid, ex_baud, ex_frm, ex_typ;
    logic [FW:0] ex_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expand one whole frame into its per-cycle output schedule.
    function automatic void build_frame();
        int pl, nl, nbits, nn, nc, n, len;
        bit t;
        logic [2*OW-1:0] cfg;
        ent_t e;
        pl = int'(fc[2*FW-1:FW]);
        nl = int'(fc[FW-1:0]);
        nbits = pl + nl;
        if (nbits == 0) nbits = 1;
        for (int b = 0; b < nbits; b++) begin
            t = (pl > nl);
            if (t) pl--;
            else if (nl > 0) nl--;
            cfg = t ? posc : negc;
            nn = int'(cfg[2*OW-1:OW]);
            nc = int'(cfg[OW-1:0]);
            if (nn + nc == 0) nn = 1;
            n = nn + nc;
            for (int k = 0; k < n; k++) begin
                len = int'(per) + ((k < nn) ? 1 : 2);
                for (int c = 0; c < len; c++) begin
                    e.acq  = (c == len - 1);
                    e.mid  = e.acq && (k == (n + 1) / 2 - 1);
                    e.baud = e.acq && (k == n - 1);
                    e.frm  = e.baud && (b == nbits - 1);
                    e.typ  = t;
                    e.idx  = (FW+1)'(b);
                    q.push_back(e);
                end
            end
        end
    endfunction

    function automatic void model();
        ent_t e;
        if (!en) begin
            run = 1'b0;
            q.delete();
            {ex_acq, ex_mid, ex_baud, ex_frm, ex_typ} = '0;
            ex_idx = '0;
        end else if (!run || restart) begin
            run = 1'b1;
            q.delete();
            build_frame();
            {ex_acq, ex_mid, ex_baud, ex_frm} = '0;
            ex_typ = q[0].typ;
            ex_idx = q[0].idx;
        end else begin
            e = q.pop_front();
            if (q.size() == 0) build_frame();
            ex_acq  = e.acq;
            ex_mid  = e.mid;
            ex_baud = e.baud;
            ex_frm  = e.frm;
            ex_typ  = q[0].typ;
            ex_idx  = q[0].idx;
        end
    endfunction

    task automatic compare();
        chk("AcqSig", acq, ex_acq);
        chk("MidSig", mid, ex_mid);
        chk("BaudSig", baud, ex_baud);
        chk("FrameSig", frm, ex_frm);
        chk("BitType", btype, ex_typ);
        chk("BitIndex", bidx, ex_idx);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model();
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        run = 1'b0;
        q.delete();
        {ex_acq, ex_mid, ex_baud, ex_frm, ex_typ} = '0;
        ex_idx = '0;
        compare();
        @(posedge clk);
        #1;
        compare();
        rst = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return acq;
            1: return mid;
            2: return baud;
            default: return frm;
        endcase
    endfunction

    // Steps until the selected strobe is seen; -1 if the bound expires.
    task automatic cycles_to(input int sel, input int bound, output int n);
        n = 0;
        repeat (bound) begin
            step();
            n++;
            if (sig(sel)) return;
        end
        n = -1;
    endtask

    task automatic wait_idx(input int target, input int bound);
        int k;
        k = 0;
        while (bidx != (FW+1)'(target) && k < bound) begin
            step();
            k++;
        end
        chk("wait_bit_index", bidx, (FW+1)'(target));
    endtask

    localparam int ACQ = 0, MID = 1, BAUD = 2, FRM = 3;

    initial begin
        int n;
        int seq[10];
        seq = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
        #2;
        do_reset();

        // Config 1: P=4, 8 normal periods per bit, 10 short bits per frame.
        per = 13'd4; posc = {4'd8, 4'd0}; negc = {4'd8, 4'd0}; fc = {4'd0, 4'd10};
        en = 1'b1;
        step();
        cycles_to(ACQ, 50, n);   chk("t1_first_acq", n, 5);
        cycles_to(BAUD, 100, n); chk("t1_first_baud", n, 35);
        cycles_to(MID, 100, n);  chk("t1_mid_offset", n, 20);
        cycles_to(BAUD, 100, n); chk("t1_mid_to_baud", n, 20);
        cycles_to(FRM, 500, n);
        cycles_to(FRM, 500, n);  chk("t1_frame_period", n, 400);

        // Restart 17 clk into bit 3.
        wait_idx(3, 500);
        repeat (16) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("t3_pulses_after_restart", {acq, mid, baud, frm}, 4'h0);
        chk("t3_index_after_restart", bidx, 0);
        cycles_to(ACQ, 50, n);   chk("t3_acq_after_restart", n, 5);
        cycles_to(BAUD, 100, n); chk("t3_baud_after_restart", n, 35);

        // Mid-frame period change applies only from the next frame.
        wait_idx(4, 500);
        cycles_to(ACQ, 50, n);
        per = 13'd9;
        cycles_to(ACQ, 50, n);   chk("t4_acq_same_frame", n, 5);
        cycles_to(FRM, 500, n);
        cycles_to(ACQ, 50, n);   chk("t4_acq_next_frame", n, 10);
        cycles_to(BAUD, 200, n); chk("t4_bit_next_frame", n, 70);

        // Enable drop, reset mid-frame, re-enable.
        repeat (17) step();
        en = 1'b0;
        step();
        chk("t5_disable_outputs", {acq, mid, baud, frm, btype}, 5'h0);
        chk("t5_disable_index", bidx, 0);
        restart = 1'b1;
        repeat (3) step();
        restart = 1'b0;
        repeat (2) step();
        en = 1'b1;
        step();
        cycles_to(ACQ, 50, n);   chk("t5_reenable_acq", n, 10);
        repeat (150) step();
        do_reset();
        step();
        chk("t5_index_after_reset", bidx, 0);
        cycles_to(ACQ, 50, n);   chk("t5_acq_after_reset", n, 10);

        // Config 2: long bits 7 normal + 1 compensated, frame of 3 long / 7 short.
        per = 13'd9; posc = {4'd7, 4'd1}; negc = {4'd8, 4'd0}; fc = {4'd3, 4'd7};
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("t2_type_bit0", btype, seq[0]);
        for (int i = 1; i < 10; i++) begin
            cycles_to(BAUD, 200, n);
            chk("t2_bit_len", n, (seq[i-1] != 0) ? 81 : 80);
            chk("t2_type_seq", btype, seq[i]);
        end
        cycles_to(FRM, 200, n);
        cycles_to(FRM, 1000, n); chk("t2_frame_period", n, 803);

        // Config 6: everything zero, every strobe on every clk.
        per = '0; posc = '0; negc = '0; fc = '0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (10) begin
            step();
            chk("t6_all_strobes", {acq, mid, baud, frm}, 4'hf);
            chk("t6_bit_type", btype, 0);
        end

        // Longest acq period: compensated period at P = max.
        per = '1; posc = {4'd0, 4'd1}; negc = {4'd0, 4'd1}; fc = {4'd0, 4'd1};
        restart = 1'b1;
        step();
        restart = 1'b0;
        cycles_to(ACQ, 9000, n); chk("max_period_acq", n, 8193);
        chk("max_period_frame", frm, 1);

        // Randomized traffic with restarts, enable drops and config churn.
        for (int i = 0; i < 3000; i++) begin
            restart = ($urandom_range(0, 63) == 0);
            if (!en) en = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 299) == 0) en = 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                per  = PW'($urandom_range(0, 5));
                posc = {OW'($urandom_range(0, 3)), OW'($urandom_range(0, 3))};
                negc = {OW'($urandom_range(0, 3)), OW'($urandom_range(0, 3))};
                fc   = {FW'($urandom_range(0, 4)), FW'($urandom_range(0, 4))};
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
